sevseg_scan_display: RTL and testbench

Parametrised multi-digit seven-segment display controller: accepts a binary value over a valid/ready handshake, converts it to BCD with an internal sequential double-dabble engine, and time-multiplexes the digits onto a shared segment bus. It sits between application counters and the board pins. It generalises the fixed 4-digit scanner to N digits, with leading-zero blanking, per-digit decimal points, overflow indication, selectable output polarities and an anti-ghosting guard interval.

---
 rtl/sevseg_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/sevseg_scan_display.sv | 128 ++++++++++++
 tb/tb_sevseg_scan_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan display: segment codes,
// converter state encoding and the BCD-to-segment decoder.
package sevseg_pkg;

    // Active-high segment codes, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, then a single
// COMMIT cycle where o_done flags that o_bcd holds the finished result.
module bin2bcd_seq
    import sevseg_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int NDIG    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*(NDIG+1)-1:0]   o_bcd
);
    localparam int BCD_W = 4 * (NDIG + 1);
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

    conv_state_t          r_state, w_next;
    logic [VALUE_W-1:0]   r_bin;
    logic [BCD_W-1:0]     r_bcd, w_adj;
    logic [CNT_W-1:0]     r_cnt;

    // The extra top nibble makes overflow of the displayable range exact
    always_comb begin
        w_adj = r_bcd;
        for (int n = 0; n < NDIG + 1; n++)
            if (r_bcd[4*n +: 4] >= 4'd5)
                w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CNT_LAST) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (i_start) begin
                    r_bin <= i_bin;
                    r_bcd <= '0;
                    r_cnt <= '0;
                end
                SHIFT: begin
                    r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == COMMIT);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/sevseg_scan_display.sv
// N-digit multiplexed seven-segment driver: handshake into the BCD converter,
// committed display registers, slot/digit scanner and polarity-adjusted outputs.
module sevseg_scan_display
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int VALUE_W        = 14,
    parameter int REFRESH_DIV    = 16000,
    parameter int GUARD          = 2,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [VALUE_W-1:0]      value_i,
    input  logic                    value_valid_i,
    output logic                    value_ready_o,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    overflow_o
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]     SLOT_GUARD = SLOT_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

    logic                    w_busy, w_done, w_accept;
    logic [BCD_W+3:0]        w_bcd;
    logic [NUM_DIGITS-1:0]   r_dp_lat, r_dp;
    logic [BCD_W-1:0]        r_bcd;
    logic                    r_ovf;
    logic [SLOT_W-1:0]       r_slot;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              w_nib;
    logic                    w_upper_zero;
    logic [6:0]              w_seg, r_seg;
    logic                    w_dp, r_dp_out;
    logic [NUM_DIGITS-1:0]   w_dig, r_dig;

    assign w_accept      = value_valid_i && !w_busy;
    assign value_ready_o = !w_busy;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .NDIG    (NUM_DIGITS)
    ) u_conv (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_start (w_accept),
        .i_bin   (value_i),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dp_lat <= '0;
            r_dp     <= '0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) r_dp_lat <= dp_i;
            if (w_done) begin
                r_bcd <= w_bcd[BCD_W-1:0];
                r_dp  <= r_dp_lat;
                r_ovf <= |w_bcd[BCD_W +: 4];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else if (r_slot == SLOT_LAST) begin
            r_slot <= '0;
            r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // Blank a digit when it and every more-significant nibble are zero
    always_comb begin
        w_nib        = r_bcd[4*r_idx +: 4];
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(r_idx) && r_bcd[4*i +: 4] != 4'd0)
                w_upper_zero = 1'b0;
        w_seg = bcd_to_seg(w_nib);
        w_dp  = r_dp[r_idx];
        if (r_ovf) begin
            w_seg = SEG_DASH;
            w_dp  = 1'b0;
        end else if (BLANK_LZ != 0 && r_idx != '0 && w_upper_zero) begin
            w_seg = SEG_BLANK;
        end
        w_dig = '0;
        if (r_slot >= SLOT_GUARD) w_dig[r_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_seg    <= SEG_OFF;
            r_dp_out <= DP_OFF;
            r_dig    <= DIG_OFF;
        end else begin
            r_seg    <= w_seg ^ SEG_OFF;
            r_dp_out <= w_dp ^ DP_OFF;
            r_dig    <= w_dig ^ DIG_OFF;
        end
    end

    assign seg_o      = r_seg;
    assign dp_o       = r_dp_out;
    assign dig_en_o   = r_dig;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_sevseg_scan_display.sv
// Bench for sevseg_scan_display: vector table, corner sequences and random
// traffic, all checked every cycle against a value-level display model.
module tb_sevseg_scan_display;
    localparam int ND = 4;
    localparam int VW = 14;
    localparam int RD = 8;
    localparam int GD = 2;

    logic          CLK;
    logic          RST_N;
    logic [VW-1:0] value_i;
    logic          value_valid_i;
    logic          value_ready_o;
    logic [ND-1:0] dp_i;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [ND-1:0] dig_en_o;
    logic          overflow_o;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    sevseg_scan_display #(
        .NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD), .GUARD(GD),
        .BLANK_LZ(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .value_i(value_i), .value_valid_i(value_valid_i),
        .value_ready_o(value_ready_o), .dp_i(dp_i), .seg_o(seg_o), .dp_o(dp_o),
        .dig_en_o(dig_en_o), .overflow_o(overflow_o)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int p10 [5] = '{1, 10, 100, 1000, 10000};

    // {dp, seg} the display should show on digit i for committed value v
    function automatic logic [7:0] look(input int v, input logic [3:0] dpm, input int i);
        if (v > 9999) return {1'b0, 7'h40};
        if (i > 0 && v < p10[i]) return {dpm[i], 7'h00};
        return {dpm[i], segtab[(v / p10[i]) % 10]};
    endfunction

    function automatic logic [3:0] en_n(input int i);
        logic [3:0] t;
        t = 4'h0;
        t[i] = 1'b1;
        return ~t;
    endfunction

    // Reference: committed value as an integer, conversion as a countdown
    int         m_val = 0, m_pend = 0, m_left = 0, m_slot = 0, m_idx = 0;
    logic [3:0] m_dp = 4'h0, m_pend_dp = 4'h0;
    logic       m_ready = 1'b1;
    logic [6:0] x_seg = 7'h00;
    logic       x_dp = 1'b0;
    logic [3:0] x_dig = 4'hF;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_val <= 0; m_dp <= 4'h0; m_ready <= 1'b1; m_left <= 0;
            m_slot <= 0; m_idx <= 0;
            x_seg <= 7'h00; x_dp <= 1'b0; x_dig <= 4'hF;
        end else begin
            {x_dp, x_seg} <= look(m_val, m_dp, m_idx);
            x_dig  <= (m_slot < GD) ? 4'hF : en_n(m_idx);
            m_slot <= (m_slot == RD - 1) ? 0 : m_slot + 1;
            if (m_slot == RD - 1) m_idx <= (m_idx + 1) % ND;
            if (m_ready) begin
                if (value_valid_i) begin
                    m_pend <= int'(value_i); m_pend_dp <= dp_i;
                    m_ready <= 1'b0; m_left <= VW + 1;
                end
            end else if (m_left == 1) begin
                m_val <= m_pend; m_dp <= m_pend_dp; m_ready <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        chk("model", {18'b0, seg_o, dp_o, dig_en_o, value_ready_o, overflow_o},
                     {18'b0, x_seg, x_dp, x_dig, m_ready, m_val > 9999});
    endtask

    task automatic send(input int v, input logic [3:0] d);
        int n;
        value_i = VW'(v); dp_i = d; value_valid_i = 1'b1;
        tick();
        value_valid_i = 1'b0;
        n = 0;
        while (value_ready_o !== 1'b1 && n < 100) begin n++; tick(); end
        chk("latency", 32'(n), 32'(VW + 1));
        tick();
    endtask

    task automatic frame_check(input string name, input logic [3:0][6:0] es,
                               input logic [3:0] ed, input logic eo);
        chk({name, "_ovf"}, 32'(overflow_o), 32'(eo));
        for (int i = 0; i < ND; i++) begin
            logic [3:0] want;
            int n;
            want = en_n(i);
            n = 0;
            while (dig_en_o !== want && n < 3 * ND * RD) begin tick(); n++; end
            chk($sformatf("%s_en%0d", name, i), 32'(dig_en_o), 32'(want));
            chk($sformatf("%s_seg%0d", name, i), 32'(seg_o), 32'(es[i]));
            chk($sformatf("%s_dp%0d", name, i), 32'(dp_o), 32'(ed[i]));
        end
    endtask

    typedef struct {
        int               val;
        logic [3:0]       dp;
        logic [3:0][6:0]  seg;
        logic [3:0]       edp;
        logic             ovf;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin
        // digit 3 is the leftmost entry in each seg concatenation
        tbl[0] = '{1234,  4'b0000, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 1'b0};
        tbl[1] = '{7,     4'b0100, {7'h00, 7'h00, 7'h00, 7'h07}, 4'b0100, 1'b0};
        tbl[2] = '{12000, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 1'b1};
        tbl[3] = '{0,     4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 1'b0};
        tbl[4] = '{9999,  4'b0001, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 4'b0001, 1'b0};
        tbl[5] = '{16383, 4'b1010, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 1'b1};
        tbl[6] = '{10000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 1'b1};
        tbl[7] = '{1000,  4'b1000, {7'h06, 7'h3F, 7'h3F, 7'h3F}, 4'b1000, 1'b0};
        tbl[8] = '{10,    4'b0110, {7'h00, 7'h00, 7'h06, 7'h3F}, 4'b0110, 1'b0};
        tbl[9] = '{100,   4'b0000, {7'h00, 7'h06, 7'h3F, 7'h3F}, 4'b0000, 1'b0};

        RST_N = 1'b0; value_valid_i = 1'b0; value_i = '0; dp_i = '0;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b1;
        tick();
        chk("rst_ready", 32'(value_ready_o), 32'd1);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_dig", 32'(dig_en_o), 32'hF);
        frame_check("rst_disp", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 1'b0);
        repeat (2 * ND * RD) tick();

        for (int t = 0; t < NV; t++) begin
            send(tbl[t].val, tbl[t].dp);
            frame_check($sformatf("vec%0d", t), tbl[t].seg, tbl[t].edp, tbl[t].ovf);
        end

        // value offered while busy is dropped, then taken once ready
        value_i = VW'(99); dp_i = 4'h0; value_valid_i = 1'b1;
        tick();
        value_i = VW'(55);
        tick();
        value_valid_i = 1'b0;
        for (int n = 0; n < 100 && value_ready_o !== 1'b1; n++) tick();
        tick();
        frame_check("busy_drop", {7'h00, 7'h00, 7'h6F, 7'h6F}, 4'b0000, 1'b0);
        send(55, 4'h0);
        frame_check("after_drop", {7'h00, 7'h00, 7'h6D, 7'h6D}, 4'b0000, 1'b0);

        // reset mid-conversion discards the value in flight
        value_i = VW'(9999); dp_i = 4'hF; value_valid_i = 1'b1;
        tick();
        value_valid_i = 1'b0;
        repeat (4) tick();
        #2 RST_N = 1'b0;
        tick();
        chk("midrst_ready", 32'(value_ready_o), 32'd1);
        chk("midrst_dig", 32'(dig_en_o), 32'hF);
        chk("midrst_seg", 32'(seg_o), 32'h0);
        #2 RST_N = 1'b1;
        repeat (VW + 4) tick();
        frame_check("midrst_disp", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int mode, k, gap, v;
            mode = $urandom_range(0, 3);
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                case (mode)
                    0:       v = $urandom_range(0, 9);
                    1:       v = $urandom_range(9990, 10010);
                    2:       v = $urandom_range(0, 16383);
                    default: v = $urandom_range(0, 999);
                endcase
                value_i = VW'(v); dp_i = 4'($urandom); value_valid_i = 1'b1;
                tick();
            end
            value_valid_i = 1'b0;
            gap = $urandom_range(0, 40);
            repeat (gap) tick();
        end
        repeat (2 * ND * RD) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
